// File: rtl/tile_ram_arbiter.sv
// Tile RAM slot arbiter. Each cycle it hands the single RAM port to scanout, the map
// initializer, the CPU posted-write FIFO or a CPU read, in that priority order.
//
// state      | meaning
// ST_IDLE    | waiting for a CPU request; writes push to the FIFO, reads wait for a slot
// ST_ISSUED  | read address went out last cycle; capture ram_dout this cycle
// ST_ACK     | one-cycle cpu_ack pulse
// ST_RELEASE | waiting for cpu_req to drop before accepting a new request
module tile_ram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vid_active,
  input  logic [9:0] vid_addr,
  output logic [7:0] vid_data,
  input  logic       init_req,
  input  logic [9:0] init_addr,
  input  logic [7:0] init_wdata,
  output logic       init_gnt,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout,
  output logic       fifo_full,
  output logic       fifo_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUED  = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } cpu_state_t;

  typedef enum logic [2:0] {
    OWN_NONE  = 3'd0,
    OWN_VID   = 3'd1,
    OWN_INIT  = 3'd2,
    OWN_DRAIN = 3'd3,
    OWN_CPURD = 3'd4
  } owner_t;

  cpu_state_t state, state_nxt;
  owner_t     owner;

  logic [17:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [17:0]      fifo_head;
  logic             push;
  logic             pop;

  logic [9:0] addr_hold;
  logic [7:0] din_hold;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign vid_data   = ram_dout;
  assign cpu_ack    = (state == ST_ACK);

  // Reads wait for an empty FIFO so a read never overtakes a posted write.
  always_comb begin
    owner = OWN_NONE;
    if (vid_active)
      owner = OWN_VID;
    else if (init_req)
      owner = OWN_INIT;
    else if (!fifo_empty)
      owner = OWN_DRAIN;
    else if (state == ST_IDLE && cpu_req && !cpu_we)
      owner = OWN_CPURD;
  end

  always_comb begin
    ram_addr = addr_hold;
    ram_din  = din_hold;
    ram_we   = 1'b0;
    init_gnt = 1'b0;
    pop      = 1'b0;
    case (owner)
      OWN_VID: begin
        ram_addr = vid_addr;
      end
      OWN_INIT: begin
        ram_addr = init_addr;
        ram_din  = init_wdata;
        ram_we   = 1'b1;
        init_gnt = 1'b1;
      end
      OWN_DRAIN: begin
        ram_addr = fifo_head[17:8];
        ram_din  = fifo_head[7:0];
        ram_we   = 1'b1;
        pop      = 1'b1;
      end
      OWN_CPURD: begin
        ram_addr = cpu_addr;
      end
      default: ;
    endcase
    // Keep the RAM port quiet while reset is held, whatever the requesters do.
    if (!reset) begin
      ram_addr = '0;
      ram_din  = '0;
      ram_we   = 1'b0;
      init_gnt = 1'b0;
      pop      = 1'b0;
    end
  end

  // A full FIFO still takes a push when the head drains on the same edge.
  assign push = reset && (state == ST_IDLE) && cpu_req && cpu_we && (!fifo_full || pop);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (push)
          state_nxt = ST_ACK;
        else if (owner == OWN_CPURD)
          state_nxt = ST_ISSUED;
      end
      ST_ISSUED:  state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (!cpu_req)
          state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cpu_rdata <= '0;
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      state     <= state_nxt;
      addr_hold <= ram_addr;
      din_hold  <= ram_din;
      if (state == ST_ISSUED)
        cpu_rdata <= ram_dout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {cpu_addr, cpu_wdata};
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: a behavioural tile RAM, directed scenarios, and a
// scoreboard that pairs every RAM write and CPU ack with its queued expectation.
module tb_tile_ram_arbiter;

  logic       clk;
  logic       reset;
  logic       vid_active;
  logic [9:0] vid_addr;
  logic [7:0] vid_data;
  logic       init_req;
  logic [9:0] init_addr;
  logic [7:0] init_wdata;
  logic       init_gnt;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic       fifo_full;
  logic       fifo_empty;

  typedef struct {
    logic       is_read;
    logic [7:0] data;
  } ack_exp_t;

  ack_exp_t    ack_q[$];
  logic [17:0] wr_q[$];
  logic [7:0]  mem [1024];
  int          checks;
  int          errors;

  tile_ram_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .vid_active(vid_active), .vid_addr(vid_addr), .vid_data(vid_data),
    .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata), .init_gnt(init_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_ram_write", {ram_addr, ram_din}, 0);
        end else begin
          logic [17:0] e;
          e = wr_q.pop_front();
          check("ram_write", {ram_addr, ram_din}, e);
        end
      end
      if (cpu_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          ack_exp_t a;
          a = ack_q.pop_front();
          if (a.is_read)
            check("read_data", cpu_rdata, a.data);
          else
            check("write_ack", 1, 1 - 0 * cpu_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  // From ACK cycle: drop request, then land in an IDLE cycle.
  task automatic release_req();
    tick();
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, input int exp_lat);
    int lat;
    ack_exp_t e;
    e.is_read = 1'b0;
    e.data    = 8'h00;
    ack_q.push_back(e);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    wait_ack(20, lat);
    check("write_latency", lat, exp_lat);
    release_req();
  endtask

  task automatic cpu_read(input logic [9:0] a, input logic [7:0] d, input int hold);
    int lat;
    ack_exp_t e;
    e.is_read = 1'b1;
    e.data    = d;
    ack_q.push_back(e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    check("read_grant_addr", ram_addr, a);
    check("read_grant_we", ram_we, 0);
    wait_ack(20, lat);
    check("read_latency", lat, 2);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("held_req_no_ack", cpu_ack, 0);
    end
    release_req();
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h055] = 8'hA7;
    reset = 1'b0;
    vid_active = 1'b0; vid_addr = '0;
    init_req = 1'b0; init_addr = '0; init_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_init_gnt", init_gnt, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_fifo_full", fifo_full, 0);
    tick();
    reset = 1'b1;
    tick();

    // Idle-bus read: address at grant, ack two cycles later
    cpu_read(10'h055, 8'hA7, 0);

    // Video holds off INIT and drain; then INIT first, drain in order
    vid_active = 1'b1; vid_addr = 10'h055;
    cpu_write(10'h010, 8'hC1, 1);
    cpu_write(10'h011, 8'hC2, 1);
    init_req = 1'b1; init_addr = 10'h100; init_wdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("vid_ram_we", ram_we, 0);
      check("vid_init_gnt", init_gnt, 0);
      check("vid_data", vid_data, 8'hA7);
      tick();
    end
    check("two_entries_not_empty", fifo_empty, 0);
    wr_q.push_back({10'h100, 8'h5A});
    wr_q.push_back({10'h101, 8'h5B});
    wr_q.push_back({10'h010, 8'hC1});
    wr_q.push_back({10'h011, 8'hC2});
    vid_active = 1'b0;
    @(negedge clk);
    check("init_gnt_0", init_gnt, 1);
    tick();
    init_addr = 10'h101; init_wdata = 8'h5B;
    @(negedge clk);
    check("init_gnt_1", init_gnt, 1);
    tick();
    init_req = 1'b0;
    @(negedge clk);
    check("init_gnt_off", init_gnt, 0);
    repeat (3) tick();
    check("drained_empty", fifo_empty, 1);

    // Held request after ack yields no second ack; a fresh request does
    cpu_read(10'h100, 8'h5A, 4);
    cpu_read(10'h101, 8'h5B, 0);

    // Fill FIFO under video, fifth write stalls until a drain frees a slot
    vid_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back({10'(10'h200 + i), 8'(8'h31 + i)});
      cpu_write(10'(10'h200 + i), 8'(8'h31 + i), 1);
    end
    check("fifo_full_at_4", fifo_full, 1);
    begin
      ack_exp_t e;
      e.is_read = 1'b0;
      e.data    = 8'h00;
      ack_q.push_back(e);
    end
    wr_q.push_back({10'h204, 8'h35});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h204; cpu_wdata = 8'h35;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("full_stall_no_ack", cpu_ack, 0);
    end
    tick();
    vid_active = 1'b0;
    wait_ack(20, lat);
    check("full_push_with_pop_latency", lat, 1);
    release_req();
    repeat (6) tick();
    check("burst_drained_empty", fifo_empty, 1);

    // Read-after-write: read waits for the drain, returns the posted data
    vid_active = 1'b1;
    wr_q.push_back({10'h3FF, 8'h11});
    cpu_write(10'h3FF, 8'h11, 1);
    begin
      ack_exp_t e;
      e.is_read = 1'b1;
      e.data    = 8'h11;
      ack_q.push_back(e);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("raw_stall_addr", ram_addr, 10'h055);
      check("raw_stall_ack", cpu_ack, 0);
      tick();
    end
    vid_active = 1'b0;
    wait_ack(20, lat);
    check("raw_read_after_drain_latency", lat, 3);
    release_req();

    // Reset with three posted writes pending: all discarded
    vid_active = 1'b1;
    cpu_write(10'h300, 8'hE0, 1);
    cpu_write(10'h301, 8'hE1, 1);
    cpu_write(10'h302, 8'hE2, 1);
    check("three_pending_not_full", fifo_full, 0);
    check("three_pending_not_empty", fifo_empty, 0);
    reset = 1'b0;
    vid_active = 1'b0;
    @(negedge clk);
    check("rst_mid_fifo_empty", fifo_empty, 1);
    check("rst_mid_ack", cpu_ack, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_write", ram_we, 0);
      tick();
    end

    // Reset with a read in flight: no ack, data cleared
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h055;
    tick();
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_issued_ack", cpu_ack, 0);
    check("rst_issued_rdata", cpu_rdata, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_ack", cpu_ack, 0);
      tick();
    end

    check("pending_writes_left", wr_q.size(), 0);
    check("pending_acks_left", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tile_ram_arbiter.md
TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, CPU posted-write FIFO entries (power of two, >=2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 vid_active  input  1  video scanout owns RAM this cycle.
REQ-005 vid_addr  input  10  scanout address {row,col}.
REQ-006 vid_data  output  8  scanout read data (ram_dout passthrough).
REQ-007 init_req  input  1  map initializer write request.
REQ-008 init_addr  input  10  initializer write address.
REQ-009 init_wdata  input  8  initializer write data.
REQ-010 init_gnt  output  1  initializer write performed this cycle.
REQ-011 cpu_req  input  1  CPU request, 4-phase handshake.
REQ-012 cpu_we  input  1  1 = write, 0 = read.
REQ-013 cpu_addr  input  10  CPU address.
REQ-014 cpu_wdata  input  8  CPU write data.
REQ-015 cpu_ack  output  1  one-cycle completion pulse.
REQ-016 cpu_rdata  output  8  registered CPU read data.
REQ-017 ram_addr  output  10  tile RAM address.
REQ-018 ram_din  output  8  tile RAM write data.
REQ-019 ram_we  output  1  tile RAM write enable.
REQ-020 ram_dout  input  8  tile RAM read data, valid 1 cycle after address.
REQ-021 fifo_full / fifo_empty  output  1 each  posted-write FIFO status.

Function
REQ-022 Slot owner chosen combinationally each cycle, fixed priority: VID (vid_active) > INIT (init_req) > DRAIN (FIFO non-empty) > CPURD (FSM IDLE, cpu_req=1, cpu_we=0, FIFO empty) > NONE.
REQ-023 VID: ram_addr=vid_addr, ram_we=0; vid_data = ram_dout, 1-cycle latency.
REQ-024 INIT: ram_addr=init_addr, ram_din=init_wdata, ram_we=1, init_gnt=1; init_gnt=0 otherwise.
REQ-025 DRAIN: head entry written (ram_we=1), head popped same edge.
REQ-026 CPURD: ram_addr=cpu_addr, ram_we=0; FSM IDLE->ISSUED.
REQ-027 NONE: ram_we=0, ram_addr holds last value.
REQ-028 CPU FSM states IDLE, ISSUED, ACK, RELEASE.
REQ-029 IDLE, cpu_req=1, cpu_we=1, FIFO not full: push {cpu_addr,cpu_wdata}, go ACK; if full, stay IDLE (stall, no ack).
REQ-030 ISSUED: cpu_rdata <= ram_dout, go ACK (unconditional; owner change irrelevant since address already issued).
REQ-031 ACK: cpu_ack=1 for exactly this cycle, go RELEASE.
REQ-032 RELEASE: wait for cpu_req=0, then IDLE; no new request sampled before.
REQ-033 Read latency: cpu_ack exactly 2 cycles after CPURD grant cycle; write ack 1 cycle after push.
REQ-034 CPU reads never granted while FIFO non-empty (read-after-write ordering).
REQ-035 FIFO: read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH; simultaneous push and pop keep count, allowed when full (pop frees slot same edge, push accepted).
REQ-036 fifo_full = (count==FIFO_DEPTH); fifo_empty = (count==0).
REQ-037 Writes to tile RAM occur in FIFO order; INIT writes may interleave between FIFO entries.

Reset
REQ-038 reset low asynchronously: FSM=IDLE, FIFO flushed (pointers, count 0), cpu_ack=0, cpu_rdata=0, ram_addr=0, ram_din=0, ram_we=0, init_gnt=0, fifo_empty=1, fifo_full=0.
REQ-039 Reset mid-transaction discards pending FIFO writes and in-flight reads; no ack issued; requester must re-issue.

Verification
REQ-040 vid_active=1, init_req=1, FIFO holding 2 entries -> ram_we=0 all video cycles; vid_active drop -> INIT writes first, then 2 drain writes in order.
REQ-041 RAM addr 0x055=0xA7, idle bus, CPU read 0x055 at cycle N -> ram_addr=0x055 at N, cpu_ack=1 at N+2, cpu_rdata=0xA7.
REQ-042 5 back-to-back CPU writes, vid_active=1 throughout, depth 4 -> 4 acks, fifo_full=1, 5th stalls; vid_active drop -> drain frees slot, 5th acked, all 5 written in order.
REQ-043 CPU write 0x3FF=0x11 then read 0x3FF -> read granted only after drain, returns 0x11.
REQ-044 reset asserted with FSM in ISSUED and FIFO count 3 -> cpu_ack stays 0, count 0, no ram_we after release.
REQ-045 cpu_req held high after ack -> FSM stays RELEASE, no second ack until req low then high.
